// File: rtl/jpeg_job_sched.sv
// jpeg_job_sched: host-side job scheduler in front of the JPEG encoder's CSR slave.
//
// Software stages a frame descriptor (width, height, src, dst) and pushes it into
// a small job queue. The scheduler pops jobs one at a time, programs the encoder,
// starts it, waits for its done pulse, reads back the output size, and posts
// {job id, size} into a result queue. The host pops results at its own pace.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset (shared with the encoder)
//   h_address      host register word offset (0..7)
//   h_read         host read strobe; h_readdata is combinational and 0 when low
//   h_write        host write strobe, h_writedata in native little-endian order
//   irq            level interrupt: irq_en && results pending (registered)
//   e_address      encoder CSR offset
//   e_read/e_write encoder strobes, at most one active per cycle
//   e_writedata    encoder write data, byte-reversed encoder format
//   e_readdata     encoder read data, combinational, byte-reversed
//   e_irq          encoder done pulse, one cycle, honoured only while waiting

module jpeg_job_sched #(
    parameter int DEPTH  = 4,   // job queue entries, power of 2, 2..128
    parameter int RDEPTH = 4    // result queue entries, power of 2, 2..128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  h_address,
    input  logic        h_read,
    input  logic        h_write,
    input  logic [31:0] h_writedata,
    output logic [31:0] h_readdata,
    output logic        irq,
    output logic [2:0]  e_address,
    output logic        e_read,
    output logic        e_write,
    output logic [31:0] e_writedata,
    input  logic [31:0] e_readdata,
    input  logic        e_irq
);

    localparam int JAW = $clog2(DEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam logic [JAW:0] JOB_CAP = DEPTH[JAW:0];
    localparam logic [RAW:0] RES_CAP = RDEPTH[RAW:0];

    typedef enum logic [3:0] {
        S_IDLE, S_WR_W, S_WR_H, S_WR_SRC, S_WR_DST, S_START, S_WAIT, S_RD_SIZE, S_POST
    } state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] width;
        logic [15:0] height;
        logic [31:0] src;
        logic [31:0] dst;
    } job_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] size;
    } result_t;

    // Full 32-bit byte reversal between native and encoder order (self-inverse).
    function automatic logic [31:0] swap32(input logic [31:0] a);
        return {a[7:0], a[15:8], a[23:16], a[31:24]};
    endfunction

    // 16-bit dimensions travel in the upper half, byte-reversed.
    function automatic logic [31:0] pack_dim(input logic [15:0] v);
        return {v[7:0], v[15:8], 16'h0000};
    endfunction

    state_t         state, state_nxt;

    logic [15:0]    st_width, st_height;
    logic [31:0]    st_src, st_dst;
    logic           irq_en, overflow, fmt_err;
    logic [7:0]     next_id;

    job_t           job_mem [DEPTH];
    logic [JAW-1:0] j_wr_ptr, j_rd_ptr;
    logic [JAW:0]   j_cnt;

    result_t        res_mem [RDEPTH];
    logic [RAW-1:0] r_wr_ptr, r_rd_ptr;
    logic [RAW:0]   r_cnt;

    job_t           cur_job;
    logic [31:0]    cur_size;

    logic           push_req, geom_ok, j_full, job_push, job_pop;
    logic           r_full, res_empty, res_push, res_pop;
    logic [7:0]     j_cnt8, r_cnt8;

    // Fullness is judged on the count before any same-cycle dispatch pop.
    assign push_req  = h_write && (h_address == 3'd4);
    assign geom_ok   = (st_width != 16'd0) && (st_height != 16'd0) &&
                       (st_width[2:0] == 3'd0) && (st_height[2:0] == 3'd0);
    assign j_full    = (j_cnt == JOB_CAP);
    assign job_push  = push_req && geom_ok && !j_full;
    assign r_full    = (r_cnt == RES_CAP);
    assign res_empty = (r_cnt == '0);
    assign res_pop   = h_write && (h_address == 3'd5) && !res_empty;
    assign j_cnt8    = 8'(j_cnt);
    assign r_cnt8    = 8'(r_cnt);

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (j_cnt != '0) state_nxt = S_WR_W;
            S_WR_W:    state_nxt = S_WR_H;
            S_WR_H:    state_nxt = S_WR_SRC;
            S_WR_SRC:  state_nxt = S_WR_DST;
            S_WR_DST:  state_nxt = S_START;
            S_START:   state_nxt = S_WAIT;
            S_WAIT:    if (e_irq) state_nxt = S_RD_SIZE;
            S_RD_SIZE: state_nxt = S_POST;
            S_POST:    if (!r_full) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        e_write     = 1'b0;
        e_read      = 1'b0;
        e_address   = 3'd0;
        e_writedata = 32'h0;
        job_pop     = 1'b0;
        res_push    = 1'b0;
        case (state)
            S_IDLE:    job_pop = (j_cnt != '0);
            S_WR_W:    begin e_write = 1'b1; e_address = 3'd0; e_writedata = pack_dim(cur_job.width);  end
            S_WR_H:    begin e_write = 1'b1; e_address = 3'd1; e_writedata = pack_dim(cur_job.height); end
            S_WR_SRC:  begin e_write = 1'b1; e_address = 3'd2; e_writedata = swap32(cur_job.src);      end
            S_WR_DST:  begin e_write = 1'b1; e_address = 3'd3; e_writedata = swap32(cur_job.dst);      end
            S_START:   begin e_write = 1'b1; e_address = 3'd5; end
            S_RD_SIZE: begin e_read  = 1'b1; e_address = 3'd4; end
            S_POST:    res_push = !r_full;
            default:   ;
        endcase
    end

    // ---------------- host registers and sticky status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            st_width  <= '0;
            st_height <= '0;
            st_src    <= '0;
            st_dst    <= '0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            fmt_err   <= 1'b0;
            next_id   <= '0;
            irq       <= 1'b0;
        end else begin
            irq <= irq_en && !res_empty;
            if (h_write) begin
                case (h_address)
                    3'd0: st_width  <= h_writedata[15:0];
                    3'd1: st_height <= h_writedata[15:0];
                    3'd2: st_src    <= h_writedata;
                    3'd3: st_dst    <= h_writedata;
                    3'd6: irq_en    <= h_writedata[8];
                    3'd7: begin
                        if (h_writedata[1]) overflow <= 1'b0;
                        if (h_writedata[2]) fmt_err  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Bad geometry wins over a full queue: only fmt_err is reported.
            if (push_req) begin
                if (!geom_ok)    fmt_err  <= 1'b1;
                else if (j_full) overflow <= 1'b1;
                else             next_id  <= next_id + 8'd1;
            end
        end
    end

    // ---------------- queue storage ----------------
    // NOTE: queue storage is not reset; the pointers and counts define which
    // entries are valid, and empty-queue reads are masked to zero.
    always_ff @(posedge clk) begin
        if (job_push) job_mem[j_wr_ptr] <= '{id: next_id, width: st_width, height: st_height,
                                             src: st_src, dst: st_dst};
        if (res_push) res_mem[r_wr_ptr] <= '{id: cur_job.id, size: cur_size};
    end

    // ---------------- queue pointers, counts, active job ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            j_wr_ptr <= '0;
            j_rd_ptr <= '0;
            j_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            cur_job  <= '0;
            cur_size <= '0;
        end else begin
            if (job_push) j_wr_ptr <= j_wr_ptr + 1'b1;
            if (job_pop)  j_rd_ptr <= j_rd_ptr + 1'b1;
            case ({job_push, job_pop})
                2'b10:   j_cnt <= j_cnt + 1'b1;
                2'b01:   j_cnt <= j_cnt - 1'b1;
                default: ;
            endcase

            if (res_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (res_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({res_push, res_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase

            if (job_pop)              cur_job  <= job_mem[j_rd_ptr];
            if (state == S_RD_SIZE)   cur_size <= swap32(e_readdata);
        end
    end

    // ---------------- host read mux ----------------
    always_comb begin
        h_readdata = 32'h0;
        if (h_read) begin
            case (h_address)
                3'd0: h_readdata = {16'h0, st_width};
                3'd1: h_readdata = {16'h0, st_height};
                3'd2: h_readdata = st_src;
                3'd3: h_readdata = st_dst;
                3'd4: h_readdata = {8'h00, r_cnt8, j_cnt8, 5'b0, fmt_err, overflow,
                                    state != S_IDLE};
                3'd5: if (!res_empty) h_readdata = res_mem[r_rd_ptr].size;
                3'd6: h_readdata = {23'h0, irq_en,
                                    res_empty ? 8'h00 : res_mem[r_rd_ptr].id};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_job_sched.sv
// Self-checking bench for jpeg_job_sched. The bench plays both host and encoder:
// every accepted push queues the five expected encoder writes, the size the
// encoder model will return, and the expected {id, size} result.
module tb_jpeg_job_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  h_address = '0;
    logic        h_read = 1'b0;
    logic        h_write = 1'b0;
    logic [31:0] h_writedata = '0;
    logic [31:0] h_readdata;
    logic        irq;
    logic [2:0]  e_address;
    logic        e_read, e_write;
    logic [31:0] e_writedata;
    logic [31:0] e_readdata;
    logic        e_irq;
    logic        man_irq = 1'b0;
    logic        auto_irq = 1'b0;
    logic [31:0] enc_size = '0;

    jpeg_job_sched #(.DEPTH(4), .RDEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_readdata(h_readdata), .irq(irq),
        .e_address(e_address), .e_read(e_read), .e_write(e_write),
        .e_writedata(e_writedata), .e_readdata(e_readdata), .e_irq(e_irq)
    );

    always #5 clk = ~clk;

    assign e_irq      = man_irq | auto_irq;
    assign e_readdata = e_read ? enc_size : 32'h0;

    typedef struct { logic [2:0] a; logic [31:0] d; } enc_t;
    typedef struct { logic [7:0] id; logic [31:0] size; } res_t;
    typedef struct { logic [15:0] w; logic [15:0] h; logic [2:0] clr; bit acc; logic [31:0] st; } vec_t;

    enc_t        enc_q[$];
    res_t        res_exp[$];
    logic [31:0] disp_size_q[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, push_cyc = 0, w_cyc = 0, start_cyc = 0, rd_cyc = 0, m_cyc = 0;
    int auto_cnt = 0;
    bit auto_on = 1'b0;
    logic [7:0]  next_id_m = '0;
    logic [15:0] st_w = '0, st_h = '0;
    logic [31:0] st_src = '0, st_dst = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] swap32(input logic [31:0] a);
        return {a[7:0], a[15:8], a[23:16], a[31:24]};
    endfunction

    function automatic logic [31:0] dim(input logic [15:0] v);
        return {v[7:0], v[15:8], 16'h0000};
    endfunction

    function automatic logic [31:0] size_fn(input logic [7:0] id);
        return {8'h5A, id, ~id, 8'h3C};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got unexpected event, expected none (t=%0t)", name, $time);
    endtask

    // Encoder model and bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        auto_irq = 1'b0;
        if (rst) begin
            auto_cnt = 0;
        end else begin
            if (auto_cnt != 0) begin
                auto_cnt--;
                if (auto_cnt == 0) auto_irq = 1'b1;
            end
            if (e_write && e_read) fail_now("one_strobe");
            if (e_write) begin
                if (enc_q.size() == 0) begin
                    fail_now("unexpected_e_write");
                end else begin
                    enc_t e;
                    e = enc_q.pop_front();
                    check("e_address", {29'h0, e_address}, {29'h0, e.a});
                    check("e_writedata", e_writedata, e.d);
                end
                if (e_address == 3'd0) w_cyc = cyc;
                if (e_address == 3'd5) begin
                    start_cyc = cyc;
                    if (disp_size_q.size() == 0) fail_now("start_without_job");
                    else enc_size = swap32(disp_size_q.pop_front());
                    if (auto_on) auto_cnt = 3;
                end
            end else if (e_read) begin
                check("e_read_addr", {29'h0, e_address}, 32'd4);
                rd_cyc = cyc;
            end else begin
                check("idle_bus", {29'h0, e_address} | e_writedata, 32'h0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        h_address = a; h_writedata = d; h_write = 1'b1;
        tick(1);
        h_write = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        h_address = a; h_read = 1'b1;
        #1 d = h_readdata;
        tick(1);
        h_read = 1'b0;
    endtask

    task automatic stage_wh(input logic [15:0] w, input logic [15:0] h);
        st_w = w; st_h = h;
        host_write(3'd0, {16'h0, w});
        host_write(3'd1, {16'h0, h});
    endtask

    task automatic stage_addr(input logic [31:0] s, input logic [31:0] d);
        st_src = s; st_dst = d;
        host_write(3'd2, s);
        host_write(3'd3, d);
    endtask

    task automatic push_job(input bit acc, input logic [31:0] size);
        if (acc) begin
            enc_q.push_back('{3'd0, dim(st_w)});
            enc_q.push_back('{3'd1, dim(st_h)});
            enc_q.push_back('{3'd2, swap32(st_src)});
            enc_q.push_back('{3'd3, swap32(st_dst)});
            enc_q.push_back('{3'd5, 32'h0});
            disp_size_q.push_back(size);
            res_exp.push_back('{next_id_m, size});
            next_id_m++;
        end
        h_address = 3'd4; h_write = 1'b1;
        push_cyc = cyc;
        tick(1);
        h_write = 1'b0;
    endtask

    task automatic check_pop();
        logic [31:0] d;
        res_t e;
        if (res_exp.size() == 0) begin
            fail_now("scoreboard_empty");
        end else begin
            e = res_exp.pop_front();
            host_read(3'd6, d);
            check("res_id", {24'h0, d[7:0]}, {24'h0, e.id});
            host_read(3'd5, d);
            check("res_size", d, e.size);
            host_write(3'd5, 32'h0);
        end
    endtask

    task automatic pulse_irq();
        man_irq = 1'b1;
        m_cyc = cyc;
        tick(1);
        man_irq = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [31:0] d;

        tbl[0] = '{16'd16, 16'd8,  3'd0, 1'b1, 32'h0000_0001};
        tbl[1] = '{16'd16, 16'd8,  3'd0, 1'b1, 32'h0000_0101};
        tbl[2] = '{16'd24, 16'd16, 3'd0, 1'b1, 32'h0000_0201};
        tbl[3] = '{16'd8,  16'd12, 3'd0, 1'b0, 32'h0000_0205};
        tbl[4] = '{16'd8,  16'd8,  3'd4, 1'b1, 32'h0000_0301};
        tbl[5] = '{16'd64, 16'd64, 3'd0, 1'b1, 32'h0000_0401};
        tbl[6] = '{16'd16, 16'd0,  3'd0, 1'b0, 32'h0000_0405};
        tbl[7] = '{16'd8,  16'd8,  3'd4, 1'b0, 32'h0000_0403};
        tbl[8] = '{16'd0,  16'd8,  3'd2, 1'b0, 32'h0000_0405};
        tbl[9] = '{16'd8,  16'd8,  3'd4, 1'b0, 32'h0000_0403};

        // ---- reset state ----
        tick(4);
        rst = 1'b0;
        tick(1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ebus", {27'h0, e_write, e_read, e_address}, 32'h0);
        for (int a = 0; a < 7; a++) begin
            host_read(3'(a), d);
            check($sformatf("rst_reg%0d", a), d, 32'h0);
        end

        // ---- single job: byte order, latency, result, irq ----
        stage_wh(16'd16, 16'd8);
        stage_addr(32'h0000_1000, 32'h0000_8000);
        host_read(3'd2, d);
        check("stage_src_rb", d, 32'h0000_1000);
        push_job(1'b1, 32'h0000_0200);
        tick(12);
        check("lat_width", w_cyc - push_cyc, 32'd2);
        check("lat_start", start_cyc - push_cyc, 32'd6);
        host_read(3'd4, d);
        check("wait_status", d, 32'h0000_0001);
        pulse_irq();
        tick(1);
        host_read(3'd4, d);
        check("post_m2_status", d, 32'h0000_0001);
        host_read(3'd4, d);
        check("post_m3_status", d, 32'h0001_0000);
        check("lat_read", rd_cyc - m_cyc, 32'd1);
        check("irq_disabled", {31'h0, irq}, 32'h0);
        host_write(3'd6, 32'h0000_0100);
        tick(2);
        check("irq_enabled", {31'h0, irq}, 32'h1);
        check_pop();
        tick(2);
        check("irq_after_pop", {31'h0, irq}, 32'h0);

        // ---- table: queue depth, overflow, geometry, sticky clears ----
        stage_addr(32'h1122_3344, 32'hA0B0_C0D0);
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].clr != 3'd0) host_write(3'd7, {29'h0, tbl[i].clr});
            stage_wh(tbl[i].w, tbl[i].h);
            push_job(tbl[i].acc, size_fn(next_id_m));
            tick(2);
            host_read(3'd4, d);
            check($sformatf("tbl_status[%0d]", i), d, tbl[i].st);
        end
        host_write(3'd7, 32'h0000_0006);
        host_read(3'd4, d);
        check("w1c_status", d, 32'h0000_0401);

        // ---- result backpressure ----
        pulse_irq();
        auto_on = 1'b1;
        tick(100);
        host_read(3'd4, d);
        check("bp_status", d, 32'h0004_0001);
        check("bp_irq", {31'h0, irq}, 32'h1);
        check_pop();
        tick(1);
        host_read(3'd4, d);
        check("bp_released", d, 32'h0004_0000);
        repeat (4) check_pop();
        host_read(3'd5, d);
        check("empty_size", d, 32'h0);
        host_read(3'd6, d);
        check("empty_id", d, 32'h0000_0100);
        host_write(3'd5, 32'h0);
        host_read(3'd4, d);
        check("empty_pop_status", d, 32'h0);
        tick(2);
        check("irq_drained", {31'h0, irq}, 32'h0);

        // ---- reset mid-WAIT ----
        auto_on = 1'b0;
        stage_wh(16'd12, 16'd8);
        push_job(1'b0, 32'h0);
        stage_wh(16'd16, 16'd16);
        repeat (3) push_job(1'b1, size_fn(next_id_m));
        tick(15);
        host_read(3'd4, d);
        check("pre_rst_status", d, 32'h0000_0205);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        enc_q.delete();
        disp_size_q.delete();
        res_exp.delete();
        next_id_m = '0;
        st_w = '0; st_h = '0; st_src = '0; st_dst = '0;
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_ebus", {27'h0, e_write, e_read, e_address}, 32'h0);
        check("mid_rst_ewdata", e_writedata, 32'h0);
        host_read(3'd4, d);
        check("mid_rst_status", d, 32'h0);
        host_read(3'd6, d);
        check("mid_rst_reg6", d, 32'h0);
        host_read(3'd0, d);
        check("mid_rst_width", d, 32'h0);
        pulse_irq();
        tick(10);
        host_read(3'd4, d);
        check("stray_irq_status", d, 32'h0);
        host_read(3'd5, d);
        check("stray_irq_size", d, 32'h0);

        // ---- id wrap with result post and pop in the same cycle ----
        stage_wh(16'd32, 16'd16);
        stage_addr(32'hDEAD_BEEF, 32'h0102_0304);
        auto_on = 1'b1;
        push_job(1'b1, size_fn(next_id_m));
        tick(14);
        host_read(3'd4, d);
        check("wrap_preload", d, 32'h0001_0000);
        for (int k = 0; k < 256; k++) begin
            push_job(1'b1, size_fn(next_id_m));
            tick(4);
            host_read(3'd4, d);
            check($sformatf("wrap_status[%0d]", k), d, 32'h0001_0001);
            tick(3);
            check_pop();
        end
        host_read(3'd4, d);
        check("wrap_final_status", d, 32'h0001_0000);
        check_pop();
        tick(2);
        host_read(3'd4, d);
        check("wrap_drained", d, 32'h0);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_job_sched.md
Name: jpeg_job_sched

Overview:
Host-facing job scheduler in front of the JPEG encoder's CSR slave. Software queues frame descriptors (width, height, src, dst). The block programs the encoder, starts it, waits for its done interrupt, reads back the output size, and posts {job id, size} into a result FIFO. This lets software batch frames without servicing the encoder per frame.

Parameters:
DEPTH, 4, job queue entries (power of 2, ≥2)
RDEPTH, 4, result queue entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
h_address  in  3  host register word offset
h_read  in  1  host read strobe
h_write  in  1  host write strobe
h_writedata  in  32  host write data, native little-endian
h_readdata  out  32  host read data, combinational, 0 when !h_read
irq  out  1  level interrupt to host
e_address  out  3  encoder CSR offset
e_read  out  1  encoder read strobe
e_write  out  1  encoder write strobe
e_writedata  out  32  encoder write data, byte-reversed format
e_readdata  in  32  encoder read data, combinational, byte-reversed
e_irq  in  1  encoder done pulse, 1 cycle

Behaviour:
- Host map:
  - 0 staged width[15:0] (rw)
  - 1 staged height[15:0] (rw)
  - 2 staged src (rw)
  - 3 staged dst (rw)
  - 4 write = push staged job; read = status
  - 5 read = head result size; write = pop result
  - 6 read = head result id in [7:0]; irq_en in bit 8 (rw)
  - 7 write-1-clear sticky bits
- Status word: bit0 busy (FSM≠IDLE); bit1 overflow; bit2 fmt_err; [15:8] job count; [23:16] result count.
- Push acceptance: accepted iff job count < DEPTH (evaluated before a same-cycle FSM pop), width≠0, height≠0, width[2:0]==0 and height[2:0]==0.
  - Full queue: job dropped, overflow set.
  - Bad geometry: job dropped, fmt_err set. If both apply, only fmt_err is set.
  - Accepted job gets id = next_id; next_id is 8 bits, increments per accepted push, wraps 255→0.
- Pop on an empty result FIFO is a no-op. Reads of 5/6 with an empty FIFO return 0 in the data fields.
- A same-cycle post and pop both take effect; count is unchanged.
- Encoder byte order:
  - width/height written as {v[7:0], v[15:8], 16'b0}.
  - src/dst written as {a[7:0], a[15:8], a[23:16], a[31:24]}.
  - size read back and swapped to native order with the same mapping.
- FSM: IDLE → WR_W → WR_H → WR_SRC → WR_DST → START → WAIT → RD_SIZE → POST → IDLE.
  - IDLE: if job count > 0, pop the head into the job register and go to WR_W.
  - WR_W/WR_H/WR_SRC/WR_DST/START: one cycle each, e_write=1, e_address=0/1/2/3/5. START writedata is 0.
  - WAIT: strobes low; advance on e_irq. An e_irq outside WAIT is ignored.
  - RD_SIZE: e_read=1, e_address=4; capture e_readdata in the same cycle.
  - POST: if result count < RDEPTH, push {id, size} and go to IDLE; otherwise hold in POST (backpressure, no new job dispatched).
- Latency: a push into an empty queue with FSM in IDLE at cycle N gives:
  - first e_write (width) in cycle N+2
  - START in N+6
  - if e_irq arrives at cycle M: e_read in M+1, result visible (count incremented) in M+3.
- Outputs only one encoder strobe per cycle. Strobes are low in IDLE/WAIT/POST; e_address/e_writedata are 0 when no strobe is active.
- irq = irq_en && result count > 0 (registered, one cycle after count change).
- Reset, including mid-job: FSM→IDLE, both FIFOs empty, counts 0, next_id 0, staged regs 0, sticky bits 0, irq_en 0, irq 0, all e_* outputs 0. The encoder shares rst.

Test Plan:
- Single job: width 16, height 8, src 0x1000, dst 0x8000, push; e_irq at cycle 20 with e_readdata 0x00020000 → encoder writes in order (0:0x10000000, 1:0x08000000, 2:0x00100000, 3:0x00800000, 5:0); result id 0, size 0x200; irq=1 once irq_en is set.
- Queue depth: push 5 jobs without firing e_irq (DEPTH=4) → first job dispatched, 4 queued; 6th push sets overflow, job count stays 4; W1C on 7 bit1 clears overflow.
- Bad geometry: width 12 push → dropped, fmt_err=1, job count unchanged, next_id unchanged.
- Result backpressure: RDEPTH=4, complete 5 jobs without popping → FSM holds in POST with busy=1; one pop → 5th result posted next cycle, ids 0..4 in order.
- Reset mid-WAIT: rst asserted with 2 jobs queued → status reads 0, e_* low, irq 0; a stray e_irq afterwards produces no result.
- Id wrap and concurrency: 256 jobs with same-cycle push/pop of results → ids wrap 255→0, counts remain consistent.
